// File: rtl/sleep_unit_mc_pkg.sv
// Shared types and register map for the multi-core sleep controller.
package sleep_unit_mc_pkg;

  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic [1:0] {StRun, StShutdown, StSleep, StWake} sleep_state_e;

  localparam logic [REG_ADDR_W-1:0] REG_CTRL     = 3'd0;
  localparam logic [REG_ADDR_W-1:0] REG_STATUS   = 3'd1;
  localparam logic [REG_ADDR_W-1:0] REG_ABORT    = 3'd2;
  localparam logic [REG_ADDR_W-1:0] REG_TIMEOUT  = 3'd3;
  localparam logic [REG_ADDR_W-1:0] REG_WAKE_DLY = 3'd4;

endpackage

// File: rtl/sleep_core_fsm.sv
// One sleep channel: RUN/SHUTDOWN/SLEEP/WAKE FSM with a shared phase counter.
module sleep_core_fsm
  import sleep_unit_mc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 signal,
  input  logic                 busy,
  input  logic                 ctrl,
  input  logic [CNT_WIDTH-1:0] timeout,
  input  logic [CNT_WIDTH-1:0] wake_dly,
  output logic                 fetch_en,
  output logic                 clk_gate,
  output logic                 sleeping,
  output logic                 abort
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  sleep_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 to_hit;

  // Equality compare so a reprogrammed limit below the count wraps the counter.
  assign to_hit = (timeout != '0) && (cnt_q == timeout - CntOne);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (ctrl && !signal) state_d = StShutdown;
      StShutdown: begin
        if (signal)      state_d = StRun;
        else if (!busy)  state_d = StSleep;
        else if (to_hit) state_d = StRun;
      end
      StSleep:    if (signal) state_d = (wake_dly != '0) ? StWake : StRun;
      StWake:     if (cnt_q == wake_dly - CntOne) state_d = StRun;
      default:    state_d = StRun;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StShutdown || state_q == StWake) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    fetch_en = 1'b0;
    clk_gate = 1'b1;
    sleeping = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      StRun:      fetch_en = !(ctrl && !signal);
      StShutdown: abort = !signal && busy && to_hit;
      StSleep: begin
        clk_gate = signal;
        sleeping = 1'b1;
      end
      StWake:     ;
      default:    ;
    endcase
  end

endmodule

// File: rtl/sleep_unit_mc.sv
// APB register file for NB_CORES sleep channels plus per-core FSM instances.
module sleep_unit_mc
  import sleep_unit_mc_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NB_CORES       = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NB_CORES-1:0]       signal_i,
  input  logic [NB_CORES-1:0]       core_busy_i,
  output logic [NB_CORES-1:0]       fetch_en_o,
  output logic [NB_CORES-1:0]       clk_gate_core_o
);

  logic [NB_CORES-1:0]   ctrl_q, ctrl_d, abort_q, abort_d, sleeping, abort_set;
  logic [CNT_WIDTH-1:0]  timeout_q, timeout_d, wake_dly_q, wake_dly_d;
  logic [REG_ADDR_W-1:0] reg_idx;
  logic                  wr_en, rd_en;
  logic                  unused_apb;

  assign reg_idx    = PADDR[4:2];
  assign wr_en      = PSEL && PENABLE && PWRITE;
  assign rd_en      = PSEL && PENABLE && !PWRITE;
  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign unused_apb = ^{PADDR, PWDATA};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_q     <= '0;
      abort_q    <= '0;
      timeout_q  <= '0;
      wake_dly_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      abort_q    <= abort_d;
      timeout_q  <= timeout_d;
      wake_dly_q <= wake_dly_d;
    end
  end

  // Software writes override hardware clears; hardware abort sets override W1C.
  always_comb begin
    ctrl_d     = ctrl_q & ~(sleeping | signal_i | abort_set);
    abort_d    = abort_q;
    timeout_d  = timeout_q;
    wake_dly_d = wake_dly_q;
    if (wr_en) begin
      case (reg_idx)
        REG_CTRL:     ctrl_d     = PWDATA[NB_CORES-1:0];
        REG_ABORT:    abort_d    = abort_q & ~PWDATA[NB_CORES-1:0];
        REG_TIMEOUT:  timeout_d  = PWDATA[CNT_WIDTH-1:0];
        REG_WAKE_DLY: wake_dly_d = PWDATA[CNT_WIDTH-1:0];
        default:      ;
      endcase
    end
    abort_d = abort_d | abort_set;
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_CTRL:     PRDATA = 32'(ctrl_q);
        REG_STATUS:   PRDATA = 32'(sleeping);
        REG_ABORT:    PRDATA = 32'(abort_q);
        REG_TIMEOUT:  PRDATA = 32'(timeout_q);
        REG_WAKE_DLY: PRDATA = 32'(wake_dly_q);
        default:      PRDATA = '0;
      endcase
    end
  end

  for (genvar i = 0; i < NB_CORES; i++) begin : g_core
    sleep_core_fsm #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_fsm (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .signal   (signal_i[i]),
      .busy     (core_busy_i[i]),
      .ctrl     (ctrl_q[i]),
      .timeout  (timeout_q),
      .wake_dly (wake_dly_q),
      .fetch_en (fetch_en_o[i]),
      .clk_gate (clk_gate_core_o[i]),
      .sleeping (sleeping[i]),
      .abort    (abort_set[i])
    );
  end

endmodule

// File: tb/tb_sleep_unit_mc.sv
// Directed and randomized bench for sleep_unit_mc against a phase/elapsed-time model.
module tb_sleep_unit_mc;

  localparam int AW = 12;
  localparam int NB = 4;
  localparam int MRUN = 0, MSHUT = 1, MSLEEP = 2, MWAKE = 3;

  logic          HCLK, HRESET;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic [NB-1:0] signal_i, core_busy_i, fetch_en_o, clk_gate_core_o;

  int checks = 0;
  int errors = 0;

  sleep_unit_mc #(
    .APB_ADDR_WIDTH(AW),
    .NB_CORES      (NB),
    .CNT_WIDTH     (16)
  ) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PWRITE         (PWRITE),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PRDATA         (PRDATA),
    .PREADY         (PREADY),
    .PSLVERR        (PSLVERR),
    .signal_i       (signal_i),
    .core_busy_i    (core_busy_i),
    .fetch_en_o     (fetch_en_o),
    .clk_gate_core_o(clk_gate_core_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase per core plus the cycle number the phase began.
  int unsigned   m_state[NB];
  int unsigned   m_enter[NB];
  int unsigned   ncyc = 0;
  logic [NB-1:0] m_ctrl, m_abort;
  logic [15:0]   m_to, m_wd;
  bit            model_valid = 0;

  always @(posedge HCLK) begin : model_upd
    logic [NB-1:0] clr, set;
    logic [15:0]   el;
    int unsigned   nxt;
    logic [2:0]    idx;
    if (HRESET) begin
      for (int i = 0; i < NB; i++) begin
        m_state[i] = MRUN;
        m_enter[i] = ncyc + 1;
      end
      m_ctrl = '0; m_abort = '0; m_to = '0; m_wd = '0;
      model_valid = 1;
    end else if (model_valid) begin
      clr = signal_i;
      set = '0;
      for (int i = 0; i < NB; i++) begin
        el  = 16'(ncyc - m_enter[i]);
        nxt = m_state[i];
        case (m_state[i])
          MRUN:  if (m_ctrl[i] && !signal_i[i]) nxt = MSHUT;
          MSHUT: begin
            if (signal_i[i]) nxt = MRUN;
            else if (!core_busy_i[i]) nxt = MSLEEP;
            else if (m_to != 0 && el == m_to - 16'd1) begin
              nxt = MRUN;
              set[i] = 1'b1;
            end
          end
          MSLEEP: begin
            clr[i] = 1'b1;
            if (signal_i[i]) nxt = (m_wd != 0) ? MWAKE : MRUN;
          end
          default: if (el == m_wd - 16'd1) nxt = MRUN;
        endcase
        if (nxt != m_state[i]) begin
          m_state[i] = nxt;
          m_enter[i] = ncyc + 1;
        end
      end
      clr = clr | set;
      idx = PADDR[4:2];
      m_ctrl = m_ctrl & ~clr;
      if (PSEL && PENABLE && PWRITE) begin
        case (idx)
          3'd0: m_ctrl = PWDATA[NB-1:0];
          3'd2: m_abort = m_abort & ~PWDATA[NB-1:0];
          3'd3: m_to = PWDATA[15:0];
          3'd4: m_wd = PWDATA[15:0];
          default: ;
        endcase
      end
      m_abort = m_abort | set;
    end
    ncyc++;
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge HCLK) begin : compare
    logic [NB-1:0] ef, eg, st;
    logic [31:0]   ep;
    #4;
    if (model_valid) begin
      for (int i = 0; i < NB; i++) begin
        st[i] = (m_state[i] == MSLEEP);
        ef[i] = (m_state[i] == MRUN) ? !(m_ctrl[i] && !signal_i[i]) : 1'b0;
        eg[i] = (m_state[i] == MSLEEP) ? signal_i[i] : 1'b1;
      end
      ep = '0;
      if (PSEL && PENABLE && !PWRITE) begin
        case (PADDR[4:2])
          3'd0: ep = 32'(m_ctrl);
          3'd1: ep = 32'(st);
          3'd2: ep = 32'(m_abort);
          3'd3: ep = 32'(m_to);
          3'd4: ep = 32'(m_wd);
          default: ep = '0;
        endcase
      end
      check("model_fetch_en", 32'(fetch_en_o), 32'(ef));
      check("model_clk_gate", 32'(clk_gate_core_o), 32'(eg));
      check("model_prdata", PRDATA, ep);
    end
  end

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] d);
    @(negedge HCLK);
    PADDR = {7'd0, idx, 2'b00}; PWDATA = d; PWRITE = 1; PSEL = 1; PENABLE = 1;
    @(posedge HCLK);
    #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] d);
    @(negedge HCLK);
    PADDR = {7'd0, idx, 2'b00}; PWRITE = 0; PSEL = 1; PENABLE = 1;
    #1 d = PRDATA;
    @(posedge HCLK);
    #1 PSEL = 0; PENABLE = 0;
  endtask

  task automatic read_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(idx, d);
    check(name, d, exp);
  endtask

  initial begin : main
    int k;
    HRESET = 1; PADDR = '0; PWDATA = '0; PWRITE = 0; PSEL = 0; PENABLE = 0;
    signal_i = '0; core_busy_i = '0;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 0;

    check("reset_fetch", 32'(fetch_en_o), 32'hF);
    check("reset_gate", 32'(clk_gate_core_o), 32'hF);
    check("pready_pslverr", {30'd0, PREADY, PSLVERR}, 32'h2);
    for (int r = 0; r < 8; r++) read_check("reset_reg", 3'(r), 32'h0);

    // Cores 0 and 2 go to sleep.
    apb_write(3'd0, 32'h5);
    check("ctrl_fetch_drop", 32'(fetch_en_o), 32'hA);
    repeat (2) @(posedge HCLK);
    #1 check("sleep_fetch", 32'(fetch_en_o), 32'hA);
    check("sleep_gate", 32'(clk_gate_core_o), 32'hA);
    read_check("status_sleep", 3'd1, 32'h5);
    read_check("ctrl_cleared", 3'd0, 32'h0);

    // Wake core 0 with a 3-cycle delay.
    apb_write(3'd4, 32'd3);
    @(negedge HCLK);
    signal_i[0] = 1'b1;
    #1 check("wake_gate_comb", 32'(clk_gate_core_o[0]), 32'h1);
    k = 0;
    while (k < 20) begin
      @(posedge HCLK);
      k++;
      #1;
      if (k == 1) signal_i[0] = 1'b0;
      if (fetch_en_o[0]) break;
    end
    check("wake_latency", 32'(k), 32'd4);

    // Timeout abort on busy core 1.
    apb_write(3'd3, 32'd10);
    core_busy_i[1] = 1'b1;
    apb_write(3'd0, 32'h2);
    k = 0;
    while (k < 30) begin
      @(posedge HCLK);
      k++;
      #1;
      if (fetch_en_o[1]) break;
    end
    check("timeout_latency", 32'(k), 32'd11);
    read_check("abort_set", 3'd2, 32'h2);
    read_check("abort_ctrl_clr", 3'd0, 32'h0);
    apb_write(3'd2, 32'h2);
    read_check("abort_w1c", 3'd2, 32'h0);
    core_busy_i[1] = 1'b0;

    // Signal wins over busy falling in SHUTDOWN.
    @(negedge HCLK);
    signal_i[2] = 1'b1;
    @(negedge HCLK);
    signal_i[2] = 1'b0;
    repeat (6) @(posedge HCLK);
    core_busy_i[2] = 1'b1;
    apb_write(3'd0, 32'h4);
    @(negedge HCLK);
    signal_i[2] = 1'b1;
    core_busy_i[2] = 1'b0;
    @(posedge HCLK);
    #1 signal_i[2] = 1'b0;
    check("sig_prio_fetch", 32'(fetch_en_o[2]), 32'h1);
    check("sig_prio_gate", 32'(clk_gate_core_o[2]), 32'h1);
    read_check("sig_prio_status", 3'd1, 32'h0);

    // Reset with channels in SLEEP, WAKE and SHUTDOWN.
    apb_write(3'd3, 32'd0);
    apb_write(3'd4, 32'd20);
    core_busy_i = 4'b0100;
    apb_write(3'd0, 32'hF);
    repeat (4) @(posedge HCLK);
    @(negedge HCLK);
    signal_i[1] = 1'b1;
    @(posedge HCLK);
    #1 signal_i[1] = 1'b0;
    read_check("mixed_status", 3'd1, 32'h9);
    check("mixed_fetch", 32'(fetch_en_o), 32'h0);
    @(negedge HCLK);
    HRESET = 1;
    @(posedge HCLK);
    #1 HRESET = 0;
    check("rst2_fetch", 32'(fetch_en_o), 32'hF);
    check("rst2_gate", 32'(clk_gate_core_o), 32'hF);
    for (int r = 0; r < 5; r++) read_check("rst2_reg", 3'(r), 32'h0);

    // Randomized traffic; the compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      int acc;
      logic [2:0] idx;
      @(negedge HCLK);
      HRESET = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < NB; i++) begin
        signal_i[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 9) == 0) core_busy_i[i] = ~core_busy_i[i];
      end
      acc = $urandom_range(0, 3);
      idx = 3'($urandom_range(0, 7));
      PADDR = AW'($urandom);
      PADDR[4:2] = idx;
      PWRITE = 1'($urandom_range(0, 1));
      PSEL = (acc != 0);
      PENABLE = (acc >= 2);
      if (idx == 3'd3 || idx == 3'd4) PWDATA = {16'($urandom), 16'($urandom_range(0, 12))};
      else PWDATA = $urandom;
    end
    @(negedge HCLK);
    HRESET = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; signal_i = '0;
    repeat (2) @(posedge HCLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
